// File: rtl/seg7_pkg.sv
// Shared seven-segment definitions: segment patterns, capture FSM states and anode helpers.
package seg7_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_HOLD   = 2'd2
  } seg7_state_t;

  // Active-low {g,f,e,d,c,b,a}; index is the hex value shown.
  localparam logic [6:0] SEG7_PATTERNS [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  localparam logic [3:0] SEG7_AN_BLANK = 4'b1111;
  localparam logic [3:0] SEG7_AN_DIGIT [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

  function automatic logic an_is_valid(input logic [3:0] an);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (an == SEG7_AN_DIGIT[i]) hit = 1'b1;
    end
    return hit;
  endfunction

  function automatic logic [1:0] an_index(input logic [3:0] an);
    logic [1:0] idx;
    idx = '0;
    for (int i = 0; i < 4; i++) begin
      if (an == SEG7_AN_DIGIT[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/seg7_frame_capture_if.sv
// Frame publication bundle: captured digits plus status, with a valid/ready accept.
interface seg7_frame_capture_if;
  logic [15:0] digits_out;
  logic [3:0]  dp_out;
  logic [3:0]  err_out;
  logic        frame_valid;
  logic        frame_ready;
  logic        overrun;
  logic        timeout;

  modport master (
    output digits_out, dp_out, err_out, frame_valid, overrun, timeout,
    input  frame_ready
  );

  modport slave (
    input  digits_out, dp_out, err_out, frame_valid, overrun, timeout,
    output frame_ready
  );
endinterface

// File: rtl/seg7_pattern_decode.sv
// Combinational active-low segment pattern to hex nibble lookup; valid=0 for unknown patterns.
module seg7_pattern_decode
  import seg7_pkg::*;
(
  input  logic [6:0] pattern,
  output logic       valid,
  output logic [3:0] nibble
);

  logic [15:0] match;

  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_match
      assign match[gi] = (pattern == SEG7_PATTERNS[gi]);
    end
  endgenerate

  always_comb begin
    valid  = |match;
    nibble = '0;
    for (int i = 0; i < 16; i++) begin
      if (match[i]) nibble = 4'(i);
    end
  end

endmodule

// File: rtl/seg7_frame_capture.sv
// Reconstructs the four digits of a multiplexed seven-segment display and publishes full frames.
// Decimal-point capture is enabled by defining SEG7_CAPTURE_DP_EN.
module seg7_frame_capture
  import seg7_pkg::*;
#(
  parameter int SETTLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 200000
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic [3:0]                  an_in,
  input  logic [6:0]                  seg_in,
  input  logic                        dp_in,
  seg7_frame_capture_if.master        frame_if
);

`ifdef SEG7_CAPTURE_DP_EN
  localparam bit DP_EN = 1'b1;
`else
  localparam bit DP_EN = 1'b0;
`endif

  localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [3:0]       an_reg;
  logic [6:0]       seg_reg;
  logic             dp_reg;
  logic [11:0]      sample;
  logic [11:0]      sample_prev_reg;
  seg7_state_t      state_reg, state_next;
  logic [CNT_W-1:0] settle_cnt_reg, settle_cnt_next, run_len;
  logic [TMO_W-1:0] tmo_cnt_reg;
  logic [3:0]       mask_reg, mask_set;
  logic [15:0]      slot_digits_reg, slot_digits_next;
  logic [3:0]       slot_err_reg, slot_err_next;
  logic [3:0]       slot_dp_reg, slot_dp_next;
  logic [15:0]      digits_reg;
  logic [3:0]       dp_out_reg, err_reg;
  logic             valid_reg, overrun_reg, timeout_reg;
  logic             an_valid, an_changed, capture, publish, tmo_fire, dec_valid;
  logic [1:0]       slot_idx;
  logic [3:0]       dec_nibble;

  // With dp capture disabled the dp bit is forced constant so it never breaks settling.
  assign sample     = {an_reg, seg_reg, dp_reg & DP_EN};
  assign an_valid   = an_is_valid(an_reg);
  assign an_changed = (an_reg != sample_prev_reg[11:8]);
  assign slot_idx   = an_index(an_reg);

  seg7_pattern_decode u_decode (
    .pattern (seg_reg),
    .valid   (dec_valid),
    .nibble  (dec_nibble)
  );

  always_comb begin
    state_next      = state_reg;
    settle_cnt_next = settle_cnt_reg;
    capture         = 1'b0;
    run_len         = (state_reg == ST_SETTLE && sample == sample_prev_reg)
                      ? settle_cnt_reg + 1'b1 : CNT_W'(1);
    if (!an_valid) begin
      state_next      = ST_IDLE;
      settle_cnt_next = '0;
    end else if (state_reg != ST_HOLD || an_changed) begin
      // A new anode visit or a still-settling one; HOLD ignores segment changes.
      settle_cnt_next = run_len;
      if (run_len >= CNT_W'(SETTLE_CYCLES)) begin
        capture    = 1'b1;
        state_next = ST_HOLD;
      end else begin
        state_next = ST_SETTLE;
      end
    end
  end

  always_comb begin
    slot_digits_next = slot_digits_reg;
    slot_err_next    = slot_err_reg;
    slot_dp_next     = slot_dp_reg;
    mask_set         = mask_reg;
    if (capture) begin
      slot_digits_next[{slot_idx, 2'b00} +: 4] = dec_nibble;
      slot_err_next[slot_idx] = ~dec_valid;
      slot_dp_next[slot_idx]  = ~dp_reg & DP_EN;
      mask_set[slot_idx]      = 1'b1;
    end
  end

  assign publish  = capture && (mask_set == 4'hF);
  assign tmo_fire = !capture && (mask_reg != 4'h0) && (tmo_cnt_reg == TMO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clock) begin
    if (reset) begin
      an_reg          <= SEG7_AN_BLANK;
      seg_reg         <= '1;
      dp_reg          <= 1'b1;
      sample_prev_reg <= '1;
      state_reg       <= ST_IDLE;
      settle_cnt_reg  <= '0;
      tmo_cnt_reg     <= '0;
      mask_reg        <= '0;
      slot_digits_reg <= '0;
      slot_err_reg    <= '0;
      slot_dp_reg     <= '0;
      digits_reg      <= '0;
      dp_out_reg      <= '0;
      err_reg         <= '0;
      valid_reg       <= 1'b0;
      overrun_reg     <= 1'b0;
      timeout_reg     <= 1'b0;
    end else begin
      an_reg          <= an_in;
      seg_reg         <= seg_in;
      dp_reg          <= dp_in;
      sample_prev_reg <= sample;
      state_reg       <= state_next;
      settle_cnt_reg  <= settle_cnt_next;
      slot_digits_reg <= slot_digits_next;
      slot_err_reg    <= slot_err_next;
      slot_dp_reg     <= slot_dp_next;
      timeout_reg     <= tmo_fire;
      mask_reg        <= (publish || tmo_fire) ? 4'h0 : mask_set;
      if (capture || mask_reg == 4'h0 || tmo_fire) tmo_cnt_reg <= '0;
      else                                         tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
      if (publish) begin
        digits_reg <= slot_digits_next;
        dp_out_reg <= slot_dp_next;
        err_reg    <= slot_err_next;
        valid_reg  <= 1'b1;
        if (valid_reg && !frame_if.frame_ready) overrun_reg <= 1'b1;
      end else if (valid_reg && frame_if.frame_ready) begin
        valid_reg <= 1'b0;
      end
    end
  end

  assign frame_if.digits_out  = digits_reg;
  assign frame_if.dp_out      = DP_EN ? dp_out_reg : 4'b0000;
  assign frame_if.err_out     = err_reg;
  assign frame_if.frame_valid = valid_reg;
  assign frame_if.overrun     = overrun_reg;
  assign frame_if.timeout     = timeout_reg;

endmodule

// File: tb/tb_seg7_frame_capture.sv
// Randomized and directed bench for seg7_frame_capture against a visit-based reference model.
module tb_seg7_frame_capture;

  localparam int TB_SETTLE  = 4;
  localparam int TB_TIMEOUT = 300;
  localparam logic [6:0] TB_PAT [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };
`ifdef SEG7_CAPTURE_DP_EN
  localparam bit TB_DP_EN = 1'b1;
`else
  localparam bit TB_DP_EN = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] an_in = 4'hF;
  logic [6:0] seg_in = 7'h7F;
  logic       dp_in = 1'b1;

  seg7_frame_capture_if fif();

  seg7_frame_capture #(.SETTLE_CYCLES(TB_SETTLE), .TIMEOUT_CYCLES(TB_TIMEOUT)) dut (
    .clock    (clock),
    .reset    (reset),
    .an_in    (an_in),
    .seg_in   (seg_in),
    .dp_in    (dp_in),
    .frame_if (fif)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;
  int tmo_seen = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Reference model: a "visit" is a run of samples with the same single-low anode;
  // each visit captures once, when SETTLE identical samples have been seen.
  logic        v_active, v_done;
  logic [3:0]  v_an;
  logic [11:0] v_last;
  int          v_run;
  logic [3:0]  m_slot [4];
  logic [3:0]  m_err_s, m_dp_s, m_mask;
  int          m_idle;
  logic [15:0] m_digits;
  logic [3:0]  m_dp, m_err;
  logic        m_valid, m_overrun, m_timeout;

  function automatic int tb_low_count(input logic [3:0] an);
    int z;
    z = 0;
    for (int i = 0; i < 4; i++) if (!an[i]) z++;
    return z;
  endfunction

  function automatic logic [4:0] tb_decode(input logic [6:0] p);
    for (int i = 0; i < 16; i++) if (p == TB_PAT[i]) return {1'b1, 4'(i)};
    return 5'b0;
  endfunction

  task automatic model_reset();
    v_active = 0; v_done = 0; v_an = 0; v_last = 0; v_run = 0;
    for (int i = 0; i < 4; i++) m_slot[i] = 0;
    m_err_s = 0; m_dp_s = 0; m_mask = 0; m_idle = 0;
    m_digits = 0; m_dp = 0; m_err = 0; m_valid = 0; m_overrun = 0; m_timeout = 0;
  endtask

  task automatic model_step(input logic [3:0] an, input logic [6:0] seg, input logic dp, input logic rdy);
    logic        cap;
    logic [11:0] smp;
    logic [4:0]  dec;
    int          idx;
    cap = 0; idx = 0;
    smp = {an, seg, TB_DP_EN ? dp : 1'b0};
    m_timeout = 0;
    if (tb_low_count(an) == 1) begin
      if (v_active && an == v_an) begin
        if (smp == v_last) v_run++;
        else v_run = 1;
      end else begin
        v_active = 1; v_an = an; v_done = 0; v_run = 1;
      end
      v_last = smp;
      if (!v_done && v_run >= TB_SETTLE) begin cap = 1; v_done = 1; end
    end else begin
      v_active = 0;
    end
    if (cap) begin
      for (int i = 0; i < 4; i++) if (!an[i]) idx = i;
      dec = tb_decode(seg);
      m_slot[idx] = dec[3:0];
      m_err_s[idx] = ~dec[4];
      m_dp_s[idx] = TB_DP_EN & ~dp;
      m_mask[idx] = 1;
      m_idle = 0;
      if (m_mask == 4'hF) begin
        if (m_valid && !rdy) m_overrun = 1;
        m_valid = 1;
        m_digits = {m_slot[3], m_slot[2], m_slot[1], m_slot[0]};
        m_err = m_err_s;
        m_dp = m_dp_s;
        m_mask = 0;
        $display("frame digits=%h err=%b dp=%b overrun=%b", m_digits, m_err, m_dp, m_overrun);
      end else if (m_valid && rdy) begin
        m_valid = 0;
      end
    end else begin
      if (m_valid && rdy) m_valid = 0;
      if (m_mask != 0) begin
        m_idle++;
        if (m_idle == TB_TIMEOUT) begin m_mask = 0; m_idle = 0; m_timeout = 1; end
      end else begin
        m_idle = 0;
      end
    end
  endtask

  // Two-deep delay mirrors the input register: the edge before sample n+2 acts on sample n.
  logic [3:0] d1_an, d2_an;
  logic [6:0] d1_seg, d2_seg;
  logic       d1_dp, d2_dp, r1;

  function automatic logic [31:0] dut_status();
    return {5'b0, fif.frame_valid, fif.overrun, fif.timeout, fif.dp_out, fif.err_out, fif.digits_out};
  endfunction

  task automatic tick(input logic [3:0] an, input logic [6:0] seg, input logic dp, input logic rdy);
    @(negedge clock);
    model_step(d2_an, d2_seg, d2_dp, r1);
    check_eq("status", dut_status(),
             {5'b0, m_valid, m_overrun, m_timeout, m_dp, m_err, m_digits});
    if (fif.timeout) tmo_seen++;
    d2_an = d1_an; d2_seg = d1_seg; d2_dp = d1_dp;
    d1_an = an;    d1_seg = seg;    d1_dp = dp;    r1 = rdy;
    an_in = an; seg_in = seg; dp_in = dp; fif.frame_ready = rdy;
  endtask

  task automatic show(input int d, input logic [6:0] seg, input logic dp, input int n, input logic rdy);
    logic [3:0] a;
    a = 4'b0001 << d;
    a = ~a;
    repeat (n) tick(a, seg, dp, rdy);
  endtask

  task automatic blank(input int n, input logic rdy);
    repeat (n) tick(4'hF, 7'h7F, 1'b1, rdy);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1; an_in = 4'hF; seg_in = 7'h7F; dp_in = 1; fif.frame_ready = 0;
    repeat (2) @(negedge clock);
    check_eq("reset_state", dut_status(), 32'h0);
    reset = 0;
    model_reset();
    d1_an = 4'hF; d2_an = 4'hF; d1_seg = 7'h7F; d2_seg = 7'h7F;
    d1_dp = 1; d2_dp = 1; r1 = 0;
  endtask

  initial begin
    logic [6:0] bad;
    logic [3:0] exp_dp;
    int         tmo_before;
    bad = 7'b1010101;
    fif.frame_ready = 1'b0;
    do_reset();

    // Basic scan 3,0,A,F with no consumer
    show(0, TB_PAT[3], 1, 8, 0); show(1, TB_PAT[0], 1, 8, 0);
    show(2, TB_PAT[10], 1, 8, 0); show(3, TB_PAT[15], 1, 8, 0);
    blank(3, 0);
    check_eq("scan_digits", {16'h0, fif.digits_out}, 32'hFA03);
    check_eq("scan_err", {28'h0, fif.err_out}, 32'h0);
    check_eq("scan_valid", {31'h0, fif.frame_valid}, 32'h1);

    // Second frame while the first is unaccepted
    show(0, TB_PAT[4], 1, 8, 0); show(1, TB_PAT[3], 1, 8, 0);
    show(2, TB_PAT[2], 1, 8, 0); show(3, TB_PAT[1], 1, 8, 0);
    blank(3, 0);
    check_eq("ovr_digits", {16'h0, fif.digits_out}, 32'h1234);
    check_eq("ovr_flag", {31'h0, fif.overrun}, 32'h1);
    blank(1, 1);
    check_eq("pre_accept", {31'h0, fif.frame_valid}, 32'h1);
    blank(1, 0);
    check_eq("accept", {31'h0, fif.frame_valid}, 32'h0);

    // Digit 0 toggling faster than the settle window, then stable on 5
    for (int k = 0; k < 6; k++) show(0, (k % 2) ? TB_PAT[8] : TB_PAT[3], 1, 2, 1);
    show(0, TB_PAT[5], 1, 6, 1);
    show(1, TB_PAT[9], 1, 8, 1); show(2, TB_PAT[12], 1, 8, 1); show(3, TB_PAT[14], 1, 8, 1);
    blank(3, 1);
    check_eq("toggle_digits", {16'h0, fif.digits_out}, 32'hEC95);

    // Unknown pattern on digit 2
    show(0, TB_PAT[1], 1, 8, 1); show(1, TB_PAT[2], 1, 8, 1);
    show(2, bad, 1, 8, 1); show(3, TB_PAT[3], 1, 8, 1);
    blank(3, 1);
    check_eq("bad_digits", {16'h0, fif.digits_out}, 32'h3021);
    check_eq("bad_err", {28'h0, fif.err_out}, 32'h4);

    // Partial frame abandoned by timeout
    show(0, TB_PAT[6], 1, 6, 1); show(1, TB_PAT[7], 1, 7, 1);
    tmo_before = tmo_seen;
    blank(TB_TIMEOUT + 10, 1);
    check_eq("tmo_pulses", 32'(tmo_seen - tmo_before), 32'd1);
    check_eq("tmo_keep", {16'h0, fif.digits_out}, 32'h3021);
    show(2, TB_PAT[10], 1, 8, 1); show(3, TB_PAT[11], 1, 8, 1);
    show(0, TB_PAT[8], 1, 8, 1); show(1, TB_PAT[9], 1, 8, 1);
    blank(3, 1);
    check_eq("tmo_next", {16'h0, fif.digits_out}, 32'hBA98);

    // Decimal point on digit 3 only
    show(0, TB_PAT[0], 1, 8, 1); show(1, TB_PAT[1], 1, 8, 1);
    show(2, TB_PAT[2], 1, 8, 1); show(3, TB_PAT[3], 0, 8, 1);
    blank(3, 1);
    exp_dp = TB_DP_EN ? 4'b1000 : 4'b0000;
    check_eq("dp_out", {28'h0, fif.dp_out}, {28'h0, exp_dp});

    // Reset in the middle of a frame
    show(0, TB_PAT[1], 1, 8, 1); show(1, TB_PAT[2], 1, 8, 1);
    do_reset();
    show(0, TB_PAT[13], 1, 8, 1); show(1, TB_PAT[10], 1, 8, 1);
    show(2, TB_PAT[14], 1, 8, 1); show(3, TB_PAT[13], 1, 8, 1);
    blank(3, 1);
    check_eq("post_reset", {16'h0, fif.digits_out}, 32'hDEAD);

    // Randomized scans: glitches, bad patterns, blanks, odd anodes, random consumer
    for (int s = 0; s < 60; s++) begin
      for (int d = 0; d < 4; d++) begin
        logic [6:0] p;
        logic [3:0] bl;
        logic       dpv, rdy;
        int         hold, dig;
        p    = ($urandom % 8 == 0) ? 7'($urandom) : TB_PAT[$urandom % 16];
        dpv  = 1'($urandom);
        rdy  = 1'($urandom);
        hold = 1 + $urandom % 8;
        dig  = (s % 5 == 0) ? int'($urandom % 4) : d;
        if ($urandom % 4 == 0) begin
          show(dig, p, dpv, 1 + $urandom % 3, rdy);
          show(dig, p ^ 7'h01, dpv, 1, rdy);
        end
        show(dig, p, dpv, hold, rdy);
        if ($urandom % 6 == 0) begin
          case ($urandom % 3)
            0:       bl = 4'hF;
            1:       bl = 4'h0;
            default: bl = 4'h3;
          endcase
          repeat (1 + $urandom % 2) tick(bl, 7'h7F, 1'b1, rdy);
        end
      end
    end
    blank(5, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
